// File: rtl/one_of_n_arbiter_pkg.sv
// Shared types and constants for the 3-way packet-locking arbiter.
package one_of_n_pkg;

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned CNT_W   = 8;

    localparam logic [SEL_W-1:0] SEL_NULL = 2'd3;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Next index in the 0,1,2 rotation; out-of-range inputs wrap to 0.
    function automatic logic [SEL_W-1:0] inc_mod3(input logic [SEL_W-1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : SEL_W'(idx + 2'd1);
    endfunction

endpackage

// File: rtl/one_of_n_arbiter_rr_pick_3.sv
// Combinational rotating-priority picker: first valid requester starting at rr_ptr.
module rr_pick_3
    import one_of_n_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_val,
    input  logic [SEL_W-1:0]   rr_ptr,
    output logic               found,
    output logic [SEL_W-1:0]   index
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = (rr_ptr >= SEL_W'(NUM_REQ)) ? '0 : rr_ptr;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req_val[cand]) begin
                found = 1'b1;
                index = cand;
            end
            cand = inc_mod3(cand);
        end
    end

endmodule

// File: rtl/one_of_n_arbiter.sv
// Packet-locking round-robin arbiter for three requesters into one downstream mux.
// Optional per-grant beat limit with forced release: define ONE_OF_N_ARB_TIMEOUT_EN.
module one_of_n_arbiter
    import one_of_n_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_val,
    input  logic [NUM_REQ-1:0] req_last,
    output logic [NUM_REQ-1:0] req_rdy,
    input  logic               out_rdy,
    output logic               out_val,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_REQ-1:0] grant,
    output logic               preempt
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("one_of_n_arbiter: MAX_HOLD must be in 2..255");
    end

    state_t           state, state_nx;
    logic [SEL_W-1:0] owner, owner_nx;
    logic [SEL_W-1:0] rr_ptr, rr_ptr_nx;
    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic             xfer;
    logic             last_beat;
    logic             hold_hit;
    logic             release_now;

    rr_pick_3 u_pick (
        .req_val (req_val),
        .rr_ptr  (rr_ptr),
        .found   (pick_found),
        .index   (pick_idx)
    );

    // Outputs decode the registered owner, qualified by this cycle's handshake inputs.
    always_comb begin
        sel     = SEL_NULL;
        grant   = '0;
        out_val = 1'b0;
        req_rdy = '0;
        if (state == LOCKED) begin
            sel            = owner;
            grant[owner]   = 1'b1;
            out_val        = req_val[owner];
            req_rdy[owner] = out_rdy;
        end
    end

    assign xfer        = out_val && out_rdy;
    assign last_beat   = req_last[owner];
    assign release_now = xfer && (last_beat || hold_hit);

`ifdef ONE_OF_N_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

    logic [CNT_W-1:0] beat_cnt, beat_cnt_nx;
    logic             preempt_nx;

    assign hold_hit = (CNT_W'(beat_cnt + CNT_W'(1)) == HOLD_LIMIT);

    // Counter only runs while locked, so every new grant starts from zero.
    always_comb begin
        beat_cnt_nx = beat_cnt;
        preempt_nx  = 1'b0;
        if (state != LOCKED) begin
            beat_cnt_nx = '0;
        end else if (xfer) begin
            beat_cnt_nx = release_now ? '0 : CNT_W'(beat_cnt + CNT_W'(1));
            preempt_nx  = hold_hit && !last_beat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            preempt  <= 1'b0;
        end else begin
            beat_cnt <= beat_cnt_nx;
            preempt  <= preempt_nx;
        end
    end
`else
    assign hold_hit = 1'b0;
    assign preempt  = 1'b0;
`endif

    always_comb begin
        state_nx  = state;
        owner_nx  = owner;
        rr_ptr_nx = rr_ptr;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nx = LOCKED;
                    owner_nx = pick_idx;
                end
            end
            LOCKED: begin
                if (release_now) begin
                    state_nx  = IDLE;
                    rr_ptr_nx = inc_mod3(owner);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nx;
            owner  <= owner_nx;
            rr_ptr <= rr_ptr_nx;
        end
    end

endmodule

// File: tb/tb_one_of_n_arbiter.sv
// Directed bench for one_of_n_arbiter; expected per-cycle outputs flow through a scoreboard queue.
module tb_one_of_n_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req_val = '0;
    logic [2:0] req_last = '0;
    logic [2:0] req_rdy;
    logic       out_rdy = 1'b0;
    logic       out_val;
    logic [1:0] sel;
    logic [2:0] grant;
    logic       preempt;

    typedef struct {
        logic [1:0] sel;
        logic [2:0] grant;
        logic       val;
        logic [2:0] rdy;
        logic       pre;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   xfers = 0;
    int   x0    = 0;

    one_of_n_arbiter #(.MAX_HOLD(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_val  (req_val),
        .req_last (req_last),
        .req_rdy  (req_rdy),
        .out_rdy  (out_rdy),
        .out_val  (out_val),
        .sel      (sel),
        .grant    (grant),
        .preempt  (preempt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs, compare at the falling edge.
    task automatic step(input logic r, input logic [2:0] rv, input logic [2:0] rl,
                        input logic ordy, input logic [1:0] e_sel, input logic [2:0] e_grant,
                        input logic e_val, input logic [2:0] e_rdy, input logic e_pre,
                        input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst      = r;
        req_val  = rv;
        req_last = rl;
        out_rdy  = ordy;
        e.sel = e_sel; e.grant = e_grant; e.val = e_val; e.rdy = e_rdy; e.pre = e_pre; e.tag = tag;
        sb.push_back(e);
        @(negedge clk);
        if (out_val === 1'b1 && out_rdy === 1'b1) xfers++;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty got 0 want 1", tag);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".sel"},     8'(sel),     8'(e.sel));
            chk({e.tag, ".grant"},   8'(grant),   8'(e.grant));
            chk({e.tag, ".out_val"}, 8'(out_val), 8'(e.val));
            chk({e.tag, ".req_rdy"}, 8'(req_rdy), 8'(e.rdy));
            chk({e.tag, ".preempt"}, 8'(preempt), 8'(e.pre));
        end
    endtask

    initial begin
        // Reset state
        step(1, 3'b000, 3'b000, 0, 2'd3, 3'b000, 0, 3'b000, 0, "rst");
        step(0, 3'b000, 3'b000, 0, 2'd3, 3'b000, 0, 3'b000, 0, "rst_idle");

        // Round robin, all requesters single-beat packets
        step(0, 3'b111, 3'b111, 1, 2'd3, 3'b000, 0, 3'b000, 0, "rr_i0");
        step(0, 3'b111, 3'b111, 1, 2'd0, 3'b001, 1, 3'b001, 0, "rr_g0");
        step(0, 3'b111, 3'b111, 1, 2'd3, 3'b000, 0, 3'b000, 0, "rr_i1");
        step(0, 3'b111, 3'b111, 1, 2'd1, 3'b010, 1, 3'b010, 0, "rr_g1");
        step(0, 3'b111, 3'b111, 1, 2'd3, 3'b000, 0, 3'b000, 0, "rr_i2");
        step(0, 3'b111, 3'b111, 1, 2'd2, 3'b100, 1, 3'b100, 0, "rr_g2");
        step(0, 3'b111, 3'b111, 1, 2'd3, 3'b000, 0, 3'b000, 0, "rr_i3");
        step(0, 3'b111, 3'b111, 1, 2'd0, 3'b001, 1, 3'b001, 0, "rr_g0b");
        step(0, 3'b000, 3'b000, 1, 2'd3, 3'b000, 0, 3'b000, 0, "rr_idle");

        // Requester 1, 4-beat packet with toggling out_rdy
        x0 = xfers;
        step(0, 3'b010, 3'b000, 1, 2'd3, 3'b000, 0, 3'b000, 0, "bp_i");
        step(0, 3'b010, 3'b000, 1, 2'd1, 3'b010, 1, 3'b010, 0, "bp_b1");
        step(0, 3'b010, 3'b000, 0, 2'd1, 3'b010, 1, 3'b000, 0, "bp_w1");
        step(0, 3'b010, 3'b000, 1, 2'd1, 3'b010, 1, 3'b010, 0, "bp_b2");
        step(0, 3'b010, 3'b000, 0, 2'd1, 3'b010, 1, 3'b000, 0, "bp_w2");
        step(0, 3'b010, 3'b000, 1, 2'd1, 3'b010, 1, 3'b010, 0, "bp_b3");
        step(0, 3'b010, 3'b010, 0, 2'd1, 3'b010, 1, 3'b000, 0, "bp_w3");
        step(0, 3'b010, 3'b010, 1, 2'd1, 3'b010, 1, 3'b010, 0, "bp_b4");
        step(0, 3'b000, 3'b000, 1, 2'd3, 3'b000, 0, 3'b000, 0, "bp_rel");
        chk("bp_xfers", 8'(xfers - x0), 8'd4);

        // Owner 2 stalls mid-packet; stray last flags on non-owner / invalid owner ignored
        x0 = xfers;
        step(0, 3'b101, 3'b000, 1, 2'd3, 3'b000, 0, 3'b000, 0, "st_i");
        step(0, 3'b101, 3'b000, 1, 2'd2, 3'b100, 1, 3'b100, 0, "st_b1");
        for (int i = 0; i < 3; i++)
            step(0, 3'b001, 3'b101, 1, 2'd2, 3'b100, 0, 3'b100, 0, "st_gap");
        step(0, 3'b101, 3'b100, 1, 2'd2, 3'b100, 1, 3'b100, 0, "st_last");
        step(0, 3'b001, 3'b000, 1, 2'd3, 3'b000, 0, 3'b000, 0, "st_bub");
        step(0, 3'b001, 3'b001, 1, 2'd0, 3'b001, 1, 3'b001, 0, "st_g0");
        step(0, 3'b000, 3'b000, 1, 2'd3, 3'b000, 0, 3'b000, 0, "st_idle");
        chk("st_xfers", 8'(xfers - x0), 8'd3);

        // Requester 0 streams without last while requester 1 waits
        x0 = xfers;
        step(0, 3'b001, 3'b000, 1, 2'd3, 3'b000, 0, 3'b000, 0, "to_i");
`ifdef ONE_OF_N_ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++)
            step(0, 3'b011, 3'b000, 1, 2'd0, 3'b001, 1, 3'b001, 0, "to_hold");
        step(0, 3'b011, 3'b000, 1, 2'd3, 3'b000, 0, 3'b000, 1, "to_pre");
        step(0, 3'b010, 3'b010, 1, 2'd1, 3'b010, 1, 3'b010, 0, "to_g1");
        step(0, 3'b000, 3'b000, 1, 2'd3, 3'b000, 0, 3'b000, 0, "to_idle");
        chk("to_xfers", 8'(xfers - x0), 8'd5);
`else
        for (int i = 0; i < 10; i++)
            step(0, 3'b011, 3'b000, 1, 2'd0, 3'b001, 1, 3'b001, 0, "to_hold");
        step(0, 3'b011, 3'b001, 1, 2'd0, 3'b001, 1, 3'b001, 0, "to_last");
        step(0, 3'b000, 3'b000, 1, 2'd3, 3'b000, 0, 3'b000, 0, "to_idle");
        chk("to_xfers", 8'(xfers - x0), 8'd11);
`endif

        // Reset during the second beat of a packet
        step(0, 3'b010, 3'b000, 1, 2'd3, 3'b000, 0, 3'b000, 0, "mr_i");
        step(0, 3'b010, 3'b000, 1, 2'd1, 3'b010, 1, 3'b010, 0, "mr_b1");
        step(1, 3'b010, 3'b000, 1, 2'd1, 3'b010, 1, 3'b010, 0, "mr_b2");
        step(0, 3'b111, 3'b000, 1, 2'd3, 3'b000, 0, 3'b000, 0, "mr_after");
        step(0, 3'b111, 3'b000, 1, 2'd0, 3'b001, 1, 3'b001, 0, "mr_g0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/one_of_n_arbiter.md
ONE_OF_N_ARBITER -- requirements
Module: one_of_n_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16: max beats per grant when the timeout feature is compiled in; legal range 2..255.
REQ-002 SHALL have port clk  input  1  single clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_val  input  3  per-requester beat valid; bit i is requester i.
REQ-005 SHALL have port req_last  input  3  per-requester last beat of packet, qualified by req_val.
REQ-006 SHALL have port req_rdy  output  3  per-requester beat accepted this cycle.
REQ-007 SHALL have port out_rdy  input  1  downstream ready.
REQ-008 SHALL have port out_val  output  1  muxed beat valid.
REQ-009 SHALL have port sel  output  2  select for the downstream 3-input mux; 2'd3 = null, mux outputs zero.
REQ-010 SHALL have port grant  output  3  one-hot current owner; all zero when idle.
REQ-011 SHALL have port preempt  output  1  one-cycle pulse on forced release.

Function
REQ-012 SHALL implement two states: IDLE and LOCKED.
REQ-013 IDLE: sel=2'd3, grant=0, out_val=0, req_rdy=0.
REQ-014 IDLE with any req_val set: pick first set bit in rotating order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3); next cycle LOCKED with grant/sel = picked index; 1-cycle request-to-grant latency.
REQ-015 IDLE with req_val=0: stay IDLE, rr_ptr unchanged.
REQ-016 LOCKED owner k: out_val=req_val[k]; req_rdy[k]=out_rdy; req_rdy of non-owners=0; grant, sel, out_val, req_rdy all from registered state (grant/sel) plus combinational qualification.
REQ-017 Beat transfers when out_val && out_rdy.
REQ-018 Transfer with req_last[k]=1: next cycle IDLE, rr_ptr=(k+1) mod 3; exactly one bubble cycle before next grant.
REQ-019 Owner dropping req_val mid-packet: grant held, out_val=0, no release.
REQ-020 out_rdy low: no transfer, state and counters hold.
REQ-021 req_last on a non-owner or with req_val low: ignored.
REQ-022 Non-owner req_val changes while LOCKED: no effect on grant.
REQ-023 sel SHALL never take 2'd3 while LOCKED, never 0..2 while IDLE.

Reset
REQ-024 rst=1 at clock edge: state IDLE, rr_ptr=0, sel=2'd3, grant=0, out_val=0, req_rdy=0, preempt=0, beat counter=0.
REQ-025 Reset mid-packet: aborts grant immediately at next edge; no partial-packet bookkeeping retained.
REQ-026 rst dominates every other input in the same cycle.

Configuration
REQ-027 Macro ONE_OF_N_ARB_TIMEOUT_EN defined: 8-bit beat counter counts transfers in LOCKED, cleared on entry; on the transfer bringing count to MAX_HOLD without req_last, force release exactly as REQ-018, and assert preempt for the following cycle only.
REQ-028 Macro undefined: no counter logic, preempt tied 0, MAX_HOLD unused; grant held until req_last.
REQ-029 req_last and timeout on the same beat: normal release, preempt=0.

Structure
REQ-030 Package one_of_n_pkg SHALL hold the state enum (IDLE, LOCKED), NUM_REQ=3, SEL_NULL=2'd3.
REQ-031 Sub-module rr_pick_3 SHALL be the combinational rotating-priority picker (inputs req_val, rr_ptr; outputs found, index).

Verification
REQ-032 Reset, then req_val=3'b111 all last, out_rdy=1 -> grants 0,1,2,0 with one IDLE cycle between each; sel 0,3,1,3,2,3,0.
REQ-033 Requester 1 sends 4-beat packet, out_rdy toggling 1,0,1,0... -> exactly 4 transfers, grant=3'b010 throughout, req_rdy[1] mirrors out_rdy, release after 4th transfer.
REQ-034 Owner 2 drops req_val for 3 cycles mid-packet while req 0 valid -> grant stays 3'b100, out_val=0 those cycles, req 0 granted only after req 2 last.
REQ-035 With ONE_OF_N_ARB_TIMEOUT_EN, MAX_HOLD=4, requester 0 sends 10 beats never last -> release after 4th transfer, preempt=1 one cycle, requester 1 (pending) granted next; without macro -> all 10 transferred, no release.
REQ-036 Assert rst during 2nd beat of a LOCKED packet -> next cycle sel=2'd3, grant=0, out_val=0, rr_ptr=0; first post-reset grant goes to lowest-index requester.
